// File: rtl/memio_bridge.sv
// Memory / memory-mapped IO bridge: a combinational memory path plus a stalling IO channel FSM.
// States: IDLE = waiting for an IO strobe | ACCESS = channel selected, waiting for ready | DONE = result returned, CPU advances
module memio_bridge #(
    parameter int          NCH       = 4,
    parameter int          IO_W      = 16,
    parameter logic [31:0] IO_BASE   = 32'hFFFFFC60,
    parameter int          CH_STRIDE = 16,
    parameter int          TIMEOUT   = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         caddress,
    input  logic                memread,
    input  logic                memwrite,
    input  logic                ioread,
    input  logic                iowrite,
    input  logic [31:0]         mread_data,
    input  logic [NCH*IO_W-1:0] ioread_data,
    input  logic [NCH-1:0]      io_ready,
    input  logic [31:0]         wdata,
    output logic [31:0]         address,
    output logic [31:0]         write_data,
    output logic [31:0]         rdata,
    output logic [NCH-1:0]      io_cs,
    output logic                io_rd,
    output logic                io_wr,
    output logic                stall,
    output logic                io_err
);

    localparam int          CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          SH   = $clog2(CH_STRIDE);
    localparam logic [31:0] SPAN = 32'(NCH * CH_STRIDE);
    localparam logic [7:0]  TMO  = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       offset;
    logic [CW-1:0]     ch_dec;
    logic              hit, io_req;
    logic [CW-1:0]     ch_q;
    logic              dir_wr_q;
    logic [IO_W-1:0]   wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic              go, fin_ok, fin_to;

    // Below-base addresses wrap to a huge offset, so one unsigned compare covers both bounds.
    assign offset  = caddress - IO_BASE;
    assign hit     = offset < SPAN;
    assign ch_dec  = offset[SH +: CW];
    assign io_req  = ioread | iowrite;
    assign address = caddress;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        go         = 1'b0;
        fin_ok     = 1'b0;
        fin_to     = 1'b0;
        stall      = 1'b0;
        io_err     = 1'b0;
        io_cs      = '0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        rdata      = mread_data;
        write_data = (memwrite && !io_req) ? wdata : 32'h0;
        case (state)
            IDLE: begin
                if (io_req && !reset) begin
                    if (hit) begin
                        go       = 1'b1;
                        stall    = 1'b1;
                        state_nx = ACCESS;
                    end else begin
                        io_err = 1'b1;
                        rdata  = 32'h0;
                    end
                end
            end
            ACCESS: begin
                stall       = 1'b1;
                io_cs[ch_q] = 1'b1;
                io_rd       = !dir_wr_q;
                io_wr       = dir_wr_q;
                write_data  = dir_wr_q ? 32'(wdata_q) : 32'h0;
                if (io_ready[ch_q]) begin
                    fin_ok   = 1'b1;
                    state_nx = DONE;
                end else if (cnt_q == TMO) begin
                    fin_to   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                rdata    = rdata_q;
                io_err   = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_q     <= '0;
            dir_wr_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h0;
        end else if (go) begin
            ch_q     <= ch_dec;
            dir_wr_q <= iowrite;
            wdata_q  <= wdata[IO_W-1:0];
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h0;
        end else if (state == ACCESS) begin
            if (fin_ok) begin
                rdata_q <= dir_wr_q ? 32'h0 : 32'(ioread_data[int'(ch_q)*IO_W +: IO_W]);
                err_q   <= 1'b0;
            end else if (fin_to) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 8'h1;
            end
        end
    end

endmodule

// File: doc/memio_bridge.md
MEMIO_BRIDGE -- requirements
Module: memio_bridge

Interface
REQ-001 Parameter NCH, default 4, number of IO channels (1..16).
REQ-002 Parameter IO_W, default 16, IO data width (8..32).
REQ-003 Parameter IO_BASE, default 32'hFFFFFC60, address of channel 0.
REQ-004 Parameter CH_STRIDE, default 16, bytes per channel window (power of two, >=4).
REQ-005 Parameter TIMEOUT, default 15, maximum wait cycles for io_ready (1..255).
REQ-006 clock  in  1  system clock, all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 caddress  in  32  address from the ALU result.
REQ-009 memread, memwrite, ioread, iowrite  in  1 each  access strobes from control, level-held while stall=1.
REQ-010 mread_data  in  32  data memory read data.
REQ-011 ioread_data  in  NCH*IO_W  packed channel read data; channel k occupies bits [k*IO_W+IO_W-1 : k*IO_W].
REQ-012 io_ready  in  NCH  per-channel completion strobe.
REQ-013 wdata  in  32  store data from the decode stage.
REQ-014 address  out  32  address to memory and IO, equal to caddress.
REQ-015 write_data  out  32  data to memory or IO.
REQ-016 rdata  out  32  load data returned to the register file.
REQ-017 io_cs  out  NCH  one-hot channel select.
REQ-018 io_rd, io_wr  out  1 each  IO read and write strobes, qualified by io_cs.
REQ-019 stall  out  1  CPU hold request.
REQ-020 io_err  out  1  one-cycle pulse on an unmapped-address or timed-out IO access.

Function
REQ-021 The memory path SHALL be combinational and stall-free: rdata=mread_data when no IO transfer completes; write_data=wdata when memwrite=1.
REQ-022 Decode: hit when caddress is within [IO_BASE, IO_BASE+NCH*CH_STRIDE); ch=(caddress-IO_BASE)/CH_STRIDE, computed in 32-bit unsigned arithmetic.
REQ-023 The FSM SHALL have the states IDLE, ACCESS, DONE.
REQ-024 IDLE: with (ioread|iowrite)=1 and a hit -> ACCESS, latching ch, the direction, and wdata[IO_W-1:0]; stall=1 in the same cycle (combinational).
REQ-025 IDLE: with (ioread|iowrite)=1 and a miss -> stay in IDLE; io_err=1 for that cycle; rdata=0; no io_cs; stall=0.
REQ-026 ACCESS: io_cs[ch]=1, io_rd or io_wr per the latched direction, stall=1; the wait counter increments each cycle starting from 0.
REQ-027 ACCESS: io_ready[ch]=1 -> DONE; for a read, latch the channel ioread_data slice, zero-extended to 32 bits.
REQ-028 ACCESS: counter==TIMEOUT with no ready -> DONE; latch 0; io_err pulses for 1 cycle.
REQ-029 DONE: stall=0, io_cs=0, rdata=latched value; -> IDLE unconditionally, which gives the CPU exactly one cycle to advance.
REQ-030 Minimum IO latency: request cycle plus 1 ACCESS cycle; stall is high for >=2 cycles; rdata is valid in the DONE cycle.
REQ-031 IO write_data={zeros, latched wdata[IO_W-1:0]}; with no write strobe, write_data=0 (no high-impedance drive).
REQ-032 ioread together with memread, or iowrite together with memwrite: the IO access takes priority and the memory strobes are ignored; ioread together with iowrite: treated as a write.
REQ-033 io_ready on a non-selected channel SHALL be ignored; io_ready arriving in IDLE SHALL be ignored.
REQ-034 The wait counter width SHALL be 8 bits; it SHALL never wrap, because it is cleared on ACCESS entry.

Reset
REQ-035 reset=1 SHALL force: state IDLE, counter 0, latches 0, io_cs=0, io_rd=io_wr=0, stall=0, io_err=0, all asynchronously and without waiting for a clock edge.
REQ-036 Reset asserted mid-ACCESS SHALL abort the transfer without producing a DONE cycle or an io_err pulse.

Verification
REQ-037 memread=1, caddress=0x100, mread_data=0xDEADBEEF -> rdata=0xDEADBEEF, stall=0, io_cs=0.
REQ-038 ioread, caddress=0xFFFFFC70 (ch1), io_ready[1] high in ACCESS cycle 3, ioread_data ch1=0x1234 -> io_cs=4'b0010, stall for 4 cycles, DONE rdata=0x00001234.
REQ-039 iowrite, caddress=0xFFFFFC60, wdata=0xABCD5678, io_ready[0] after 1 cycle -> io_wr=1, write_data=0x00005678, stall 2 cycles.
REQ-040 ioread to ch2 with io_ready held low -> stall for TIMEOUT+2 cycles, io_err pulse in DONE, rdata=0.
REQ-041 ioread, caddress=0xFFFFFCA0 (unmapped when NCH=4) -> io_err=1 for 1 cycle, stall=0, rdata=0, io_cs=0.
REQ-042 reset pulse in ACCESS cycle 2 -> stall and io_cs drop before the next edge, state IDLE, no io_err.
